mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 186 ++++++++++++++++++
 tb/tb_mem_responder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: dual-port 16-bit RAM responder with a small memory-mapped
// I/O window (output FIFO, status word, input holding register).
module mem_responder #(
  parameter int          ADDR_BITS  = 10,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IO_BASE    = 16'hFF00
) (
  input  logic        CLK,
  input  logic        CtrlRst,
  input  logic        MemRead1,
  input  logic        MemWrite1,
  input  logic [15:0] MemAddr1,
  input  logic [15:0] MemWData1,
  output logic [15:0] MemRData1,
  output logic        MemValid1,
  input  logic        MemRead2,
  input  logic        MemWrite2,
  input  logic [15:0] MemAddr2,
  input  logic [15:0] MemWData2,
  output logic [15:0] MemRData2,
  output logic        MemValid2,
  output logic [15:0] OutData,
  output logic        OutValid,
  input  logic        OutReady,
  input  logic [15:0] InData,
  input  logic        InValid,
  output logic        InReady
);

  // FIFO_DEPTH is a power of two, so PW-bit pointers wrap on their own.
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [15:0]          ram      [0:(1<<ADDR_BITS)-1];
  logic [15:0]          fifo_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        wr_ptr2;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 in_full;
  logic [15:0]          hold_reg;

  logic                 io1;
  logic                 io2;
  logic [15:0]          off1;
  logic [15:0]          off2;
  logic [ADDR_BITS-1:0] idx1;
  logic [ADDR_BITS-1:0] idx2;
  logic                 rd1;
  logic                 rd2;
  logic                 wr1;
  logic                 wr2;
  logic                 ram_wr1;
  logic                 ram_wr2;
  logic                 push1;
  logic                 push2;
  logic                 push1_ok;
  logic                 push2_ok;
  logic                 pop;
  logic [CW:0]          occ_after1;
  logic                 overflow_push;
  logic                 stat_rd;
  logic                 consume;
  logic [3:0]           count_sat;
  logic [15:0]          status_word;
  logic [15:0]          io_rdata1;
  logic [15:0]          io_rdata2;
  logic [15:0]          read_word1;
  logic [15:0]          read_word2;

  // Requests are qualified by reset so nothing sampled during reset has an effect.
  assign rd1  = CtrlRst && MemRead1;
  assign rd2  = CtrlRst && MemRead2;
  assign wr1  = CtrlRst && MemWrite1;
  assign wr2  = CtrlRst && MemWrite2;

  assign io1  = (MemAddr1 >= IO_BASE);
  assign io2  = (MemAddr2 >= IO_BASE);
  assign off1 = MemAddr1 - IO_BASE;
  assign off2 = MemAddr2 - IO_BASE;
  assign idx1 = MemAddr1[ADDR_BITS-1:0];
  assign idx2 = MemAddr2[ADDR_BITS-1:0];

  assign ram_wr1 = wr1 && !io1;
  assign ram_wr2 = wr2 && !io2;
  assign push1   = wr1 && io1 && (off1 == 16'd0);
  assign push2   = wr2 && io2 && (off2 == 16'd0);

  assign stat_rd = (rd1 && io1 && (off1 == 16'd1)) || (rd2 && io2 && (off2 == 16'd1));
  assign consume = in_full &&
                   ((rd1 && io1 && (off1 == 16'd2)) || (rd2 && io2 && (off2 == 16'd2)));

  assign OutValid = (count != '0);
  assign OutData  = OutValid ? fifo_mem[rd_ptr] : 16'h0000;
  assign InReady  = !in_full;

  // Status word: sticky overflow, input-full, and a saturating 4-bit count.
  always_comb begin
    count_sat = (32'(count) > 15) ? 4'd15 : 4'(count);
    status_word = {overflow, in_full, 10'b0, count_sat};
  end

  // I/O read mux for both ports; unmapped window offsets read as zero.
  always_comb begin
    io_rdata1 = 16'h0000;
    io_rdata2 = 16'h0000;
    if (off1 == 16'd1) io_rdata1 = status_word;
    else if (off1 == 16'd2) io_rdata1 = hold_reg;
    if (off2 == 16'd1) io_rdata2 = status_word;
    else if (off2 == 16'd2) io_rdata2 = hold_reg;
  end

  assign read_word1 = io1 ? io_rdata1 : ram[idx1];
  assign read_word2 = io2 ? io_rdata2 : ram[idx2];

  // Push acceptance: a pop frees its slot first, then port 1, then port 2.
  always_comb begin
    pop           = CtrlRst && OutValid && OutReady;
    push1_ok      = push1 && (({1'b0, count} - (CW+1)'(pop)) < DEPTH_W);
    occ_after1    = {1'b0, count} + (CW+1)'(push1_ok) - (CW+1)'(pop);
    push2_ok      = push2 && (occ_after1 < DEPTH_W);
    overflow_push = (push1 && !push1_ok) || (push2 && !push2_ok);
    wr_ptr2       = wr_ptr + PW'(push1_ok);
  end

  // RAM array: port 2 written first so port 1 wins on an address collision.
  always_ff @(posedge CLK) begin
    if (ram_wr2) ram[idx2] <= MemWData2;
    if (ram_wr1) ram[idx1] <= MemWData1;
  end

  // Registered read data with single-cycle valid; data holds when idle.
  always_ff @(posedge CLK) begin
    if (!CtrlRst) begin
      MemValid1 <= 1'b0;
      MemValid2 <= 1'b0;
      MemRData1 <= 16'h0000;
      MemRData2 <= 16'h0000;
    end else begin
      MemValid1 <= MemRead1;
      MemValid2 <= MemRead2;
      if (MemRead1) MemRData1 <= read_word1;
      if (MemRead2) MemRData2 <= read_word2;
    end
  end

  // FIFO storage writes; entries past the head are never observed, so no reset.
  always_ff @(posedge CLK) begin
    if (push1_ok) fifo_mem[wr_ptr] <= MemWData1;
    if (push2_ok) fifo_mem[wr_ptr2] <= MemWData2;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (!CtrlRst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      wr_ptr <= wr_ptr + PW'(push1_ok) + PW'(push2_ok);
      count  <= count + CW'(push1_ok) + CW'(push2_ok) - CW'(pop);
    end
  end

  // Overflow flag and input holding register; a dropped push beats a status clear.
  always_ff @(posedge CLK) begin
    if (!CtrlRst) begin
      overflow <= 1'b0;
      in_full  <= 1'b0;
      hold_reg <= 16'h0000;
    end else begin
      if (overflow_push) overflow <= 1'b1;
      else if (stat_rd) overflow <= 1'b0;
      if (InValid && !in_full) begin
        hold_reg <= InData;
        in_full  <= 1'b1;
      end else if (consume) begin
        in_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios plus randomized traffic checked
// against a queue/array reference model of the responder.
module tb_mem_responder;

  localparam int          ADDR_BITS  = 10;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [15:0] IO_BASE    = 16'hFF00;
  localparam logic [15:0] IO_FIFO    = IO_BASE;
  localparam logic [15:0] IO_STAT    = IO_BASE + 16'd1;
  localparam logic [15:0] IO_IN      = IO_BASE + 16'd2;

  logic        CLK = 1'b0;
  logic        CtrlRst;
  logic        MemRead1, MemWrite1, MemRead2, MemWrite2;
  logic [15:0] MemAddr1, MemWData1, MemAddr2, MemWData2;
  logic [15:0] MemRData1, MemRData2;
  logic        MemValid1, MemValid2;
  logic [15:0] OutData;
  logic        OutValid, OutReady;
  logic [15:0] InData;
  logic        InValid, InReady;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [15:0] m_ram [0:(1<<ADDR_BITS)-1];
  logic [15:0] m_fifo [$];
  logic        m_ovf;
  logic        m_in_full;
  logic [15:0] m_hold;
  logic [15:0] e_rdata1, e_rdata2;
  logic        e_valid1, e_valid2;

  mem_responder #(
    .ADDR_BITS (ADDR_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .IO_BASE   (IO_BASE)
  ) dut (
    .CLK      (CLK),
    .CtrlRst  (CtrlRst),
    .MemRead1 (MemRead1),
    .MemWrite1(MemWrite1),
    .MemAddr1 (MemAddr1),
    .MemWData1(MemWData1),
    .MemRData1(MemRData1),
    .MemValid1(MemValid1),
    .MemRead2 (MemRead2),
    .MemWrite2(MemWrite2),
    .MemAddr2 (MemAddr2),
    .MemWData2(MemWData2),
    .MemRData2(MemRData2),
    .MemValid2(MemValid2),
    .OutData  (OutData),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .InData   (InData),
    .InValid  (InValid),
    .InReady  (InReady)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] model_status();
    int n;
    n = m_fifo.size();
    if (n > 15) n = 15;
    return {m_ovf, m_in_full, 10'b0, 4'(n)};
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] addr);
    logic [15:0] off;
    if (addr < IO_BASE) return m_ram[addr[ADDR_BITS-1:0]];
    off = addr - IO_BASE;
    if (off == 16'd1) return model_status();
    if (off == 16'd2) return m_hold;
    return 16'h0000;
  endfunction

  // Advance the model by one clock using the current inputs, then step the DUT.
  task automatic tick();
    logic [15:0] r1, r2;
    logic        cap;
    if (!CtrlRst) begin
      e_valid1 = 1'b0; e_valid2 = 1'b0;
      e_rdata1 = 16'h0; e_rdata2 = 16'h0;
      m_fifo.delete();
      m_ovf = 1'b0; m_in_full = 1'b0; m_hold = 16'h0;
    end else begin
      r1 = model_read(MemAddr1);
      r2 = model_read(MemAddr2);
      cap = InValid && !m_in_full;
      if ((MemRead1 && MemAddr1 == IO_STAT) || (MemRead2 && MemAddr2 == IO_STAT)) m_ovf = 1'b0;
      if ((MemRead1 && MemAddr1 == IO_IN) || (MemRead2 && MemAddr2 == IO_IN)) m_in_full = 1'b0;
      if (OutReady && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (MemWrite1 && MemAddr1 == IO_FIFO) begin
        if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(MemWData1); else m_ovf = 1'b1;
      end
      if (MemWrite2 && MemAddr2 == IO_FIFO) begin
        if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(MemWData2); else m_ovf = 1'b1;
      end
      if (MemWrite2 && MemAddr2 < IO_BASE) m_ram[MemAddr2[ADDR_BITS-1:0]] = MemWData2;
      if (MemWrite1 && MemAddr1 < IO_BASE) m_ram[MemAddr1[ADDR_BITS-1:0]] = MemWData1;
      if (cap) begin m_hold = InData; m_in_full = 1'b1; end
      e_valid1 = MemRead1; e_valid2 = MemRead2;
      if (MemRead1) e_rdata1 = r1;
      if (MemRead2) e_rdata2 = r2;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    MemRead1 = 1'b0; MemWrite1 = 1'b0; MemAddr1 = 16'h0; MemWData1 = 16'h0;
    MemRead2 = 1'b0; MemWrite2 = 1'b0; MemAddr2 = 16'h0; MemWData2 = 16'h0;
    OutReady = 1'b0; InValid = 1'b0; InData = 16'h0;
  endtask

  task automatic do_reset();
    idle(); CtrlRst = 1'b0; tick(); CtrlRst = 1'b1;
  endtask

  task automatic test_reset();
    idle(); CtrlRst = 1'b0; tick(); tick();
    vectors++; if (MemValid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid1: got %b expected 0", MemValid1); end
    vectors++; if (MemValid2 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid2: got %b expected 0", MemValid2); end
    vectors++; if (MemRData1 !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_rdata1: got %h expected 0000", MemRData1); end
    vectors++; if (MemRData2 !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_rdata2: got %h expected 0000", MemRData2); end
    vectors++; if (OutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_outvalid: got %b expected 0", OutValid); end
    vectors++; if (OutData !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_outdata: got %h expected 0000", OutData); end
    vectors++; if (InReady !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_inready: got %b expected 1", InReady); end
    CtrlRst = 1'b1;
  endtask

  task automatic test_aliasing();
    idle(); MemWrite1 = 1'b1; MemAddr1 = 16'h0005; MemWData1 = 16'h1234; tick();
    idle(); MemRead2 = 1'b1; MemAddr2 = 16'h0405; tick();
    vectors++; if (MemValid2 !== 1'b1) begin miscompares++; $display("[TB] FAIL alias_valid: got %b expected 1", MemValid2); end
    vectors++; if (MemRData2 !== 16'h1234) begin miscompares++; $display("[TB] FAIL alias_data: got %h expected 1234", MemRData2); end
    vectors++; if (MemValid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL alias_valid1_idle: got %b expected 0", MemValid1); end
    idle(); tick();
    vectors++; if (MemValid2 !== 1'b0) begin miscompares++; $display("[TB] FAIL alias_valid_drop: got %b expected 0", MemValid2); end
    vectors++; if (MemRData2 !== 16'h1234) begin miscompares++; $display("[TB] FAIL alias_data_hold: got %h expected 1234", MemRData2); end
  endtask

  task automatic test_collision();
    idle(); MemWrite1 = 1'b1; MemAddr1 = 16'h0010; MemWData1 = 16'h5555; tick();
    idle();
    MemWrite1 = 1'b1; MemAddr1 = 16'h0010; MemWData1 = 16'hAAAA;
    MemWrite2 = 1'b1; MemAddr2 = 16'h0010; MemWData2 = 16'hBBBB; MemRead2 = 1'b1;
    tick();
    vectors++; if (MemRData2 !== 16'h5555) begin miscompares++; $display("[TB] FAIL coll_old_data: got %h expected 5555", MemRData2); end
    idle(); MemRead1 = 1'b1; MemAddr1 = 16'h0010; tick();
    vectors++; if (MemRData1 !== 16'hAAAA) begin miscompares++; $display("[TB] FAIL coll_port1_wins: got %h expected aaaa", MemRData1); end
    idle(); MemWrite1 = 1'b1; MemAddr1 = 16'h0011; MemWData1 = 16'h0101; tick();
    idle(); MemRead1 = 1'b1; MemWrite1 = 1'b1; MemAddr1 = 16'h0011; MemWData1 = 16'h2222; tick();
    vectors++; if (MemRData1 !== 16'h0101) begin miscompares++; $display("[TB] FAIL same_port_rw: got %h expected 0101", MemRData1); end
    idle(); MemRead1 = 1'b1; MemAddr1 = 16'h0011; tick();
    vectors++; if (MemRData1 !== 16'h2222) begin miscompares++; $display("[TB] FAIL same_port_rw_after: got %h expected 2222", MemRData1); end
  endtask

  task automatic test_fifo_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      idle(); MemWrite1 = 1'b1; MemAddr1 = IO_FIFO; MemWData1 = 16'(i); tick();
    end
    idle();
    vectors++; if (OutData !== 16'h0001) begin miscompares++; $display("[TB] FAIL ovf_head: got %h expected 0001", OutData); end
    MemRead1 = 1'b1; MemAddr1 = IO_STAT; tick();
    vectors++; if (MemRData1 !== 16'h8004) begin miscompares++; $display("[TB] FAIL ovf_status1: got %h expected 8004", MemRData1); end
    tick();
    vectors++; if (MemRData1 !== 16'h0004) begin miscompares++; $display("[TB] FAIL ovf_status2: got %h expected 0004", MemRData1); end
    idle();
    for (int i = 1; i <= 4; i++) begin
      vectors++; if (OutData !== 16'(i)) begin miscompares++; $display("[TB] FAIL ovf_pop: got %h expected %h", OutData, 16'(i)); end
      OutReady = 1'b1; tick();
    end
    OutReady = 1'b0;
    vectors++; if (OutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_drained: got %b expected 0", OutValid); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp;
    for (int i = 1; i <= 4; i++) begin
      idle(); MemWrite1 = 1'b1; MemAddr1 = IO_FIFO; MemWData1 = 16'hA0 + 16'(i); tick();
    end
    idle(); MemWrite1 = 1'b1; MemAddr1 = IO_FIFO; MemWData1 = 16'h00A5; OutReady = 1'b1; tick();
    idle(); MemRead2 = 1'b1; MemAddr2 = IO_STAT; tick();
    vectors++; if (MemRData2 !== 16'h0004) begin miscompares++; $display("[TB] FAIL full_pushpop_status: got %h expected 0004", MemRData2); end
    idle();
    for (int i = 2; i <= 5; i++) begin
      exp = 16'hA0 + 16'(i);
      vectors++; if (OutData !== exp) begin miscompares++; $display("[TB] FAIL full_pushpop_order: got %h expected %h", OutData, exp); end
      OutReady = 1'b1; tick();
    end
    OutReady = 1'b0;
  endtask

  task automatic test_dual_push();
    logic [15:0] exp_q [$];
    idle(); MemWrite1 = 1'b1; MemAddr1 = IO_FIFO; MemWData1 = 16'h0011;
    MemWrite2 = 1'b1; MemAddr2 = IO_FIFO; MemWData2 = 16'h0022; tick();
    idle(); MemWrite2 = 1'b1; MemAddr2 = IO_FIFO; MemWData2 = 16'h0033; tick();
    idle(); MemWrite1 = 1'b1; MemAddr1 = IO_FIFO; MemWData1 = 16'h0055;
    MemWrite2 = 1'b1; MemAddr2 = IO_FIFO; MemWData2 = 16'h0066; tick();
    idle(); MemRead1 = 1'b1; MemAddr1 = IO_STAT; tick();
    vectors++; if (MemRData1 !== 16'h8004) begin miscompares++; $display("[TB] FAIL dual_push_status: got %h expected 8004", MemRData1); end
    idle();
    exp_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0055};
    foreach (exp_q[i]) begin
      vectors++; if (OutData !== exp_q[i]) begin miscompares++; $display("[TB] FAIL dual_push_order: got %h expected %h", OutData, exp_q[i]); end
      OutReady = 1'b1; tick();
    end
    idle(); MemRead1 = 1'b1; MemAddr1 = IO_STAT; tick(); idle();
  endtask

  task automatic test_input();
    idle(); InData = 16'h00C3; InValid = 1'b1; tick();
    InValid = 1'b0; InData = 16'h1111;
    vectors++; if (InReady !== 1'b0) begin miscompares++; $display("[TB] FAIL in_ready_fall: got %b expected 0", InReady); end
    MemRead1 = 1'b1; MemAddr1 = IO_IN; tick();
    vectors++; if (MemRData1 !== 16'h00C3) begin miscompares++; $display("[TB] FAIL in_consume_data: got %h expected 00c3", MemRData1); end
    vectors++; if (InReady !== 1'b1) begin miscompares++; $display("[TB] FAIL in_ready_rise: got %b expected 1", InReady); end
    idle(); MemRead2 = 1'b1; MemAddr2 = IO_IN; tick();
    vectors++; if (MemRData2 !== 16'h00C3) begin miscompares++; $display("[TB] FAIL in_last_value: got %h expected 00c3", MemRData2); end
    idle(); InData = 16'h0077; InValid = 1'b1; tick();
    idle(); MemRead1 = 1'b1; MemAddr1 = IO_IN; MemRead2 = 1'b1; MemAddr2 = IO_IN; tick();
    vectors++; if (MemRData1 !== 16'h0077) begin miscompares++; $display("[TB] FAIL in_dual_p1: got %h expected 0077", MemRData1); end
    vectors++; if (MemRData2 !== 16'h0077) begin miscompares++; $display("[TB] FAIL in_dual_p2: got %h expected 0077", MemRData2); end
    vectors++; if (InReady !== 1'b1) begin miscompares++; $display("[TB] FAIL in_dual_ready: got %b expected 1", InReady); end
    idle(); InData = 16'h0088; InValid = 1'b1; tick();
    InData = 16'h0099; tick();
    vectors++; if (InReady !== 1'b0) begin miscompares++; $display("[TB] FAIL in_full_hold: got %b expected 0", InReady); end
    idle(); MemRead1 = 1'b1; MemAddr1 = IO_STAT; tick();
    vectors++; if (MemRData1 !== 16'h4000) begin miscompares++; $display("[TB] FAIL in_status: got %h expected 4000", MemRData1); end
    idle(); MemRead1 = 1'b1; MemAddr1 = IO_IN; tick();
    vectors++; if (MemRData1 !== 16'h0088) begin miscompares++; $display("[TB] FAIL in_no_recapture: got %h expected 0088", MemRData1); end
    idle();
  endtask

  task automatic test_reset_midflight();
    idle(); MemWrite1 = 1'b1; MemAddr1 = 16'h001F; MemWData1 = 16'hBEEF;
    MemWrite2 = 1'b1; MemAddr2 = IO_FIFO; MemWData2 = 16'h005A;
    InData = 16'h003C; InValid = 1'b1; tick();
    idle(); MemRead1 = 1'b1; MemAddr1 = 16'h001F; tick();
    vectors++; if (MemRData1 !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL mid_pre_read: got %h expected beef", MemRData1); end
    idle(); CtrlRst = 1'b0;
    MemRead2 = 1'b1; MemAddr2 = 16'h001F;
    MemWrite1 = 1'b1; MemAddr1 = 16'h001F; MemWData1 = 16'h0000; tick();
    vectors++; if (MemValid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_valid1: got %b expected 0", MemValid1); end
    vectors++; if (MemValid2 !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_valid2: got %b expected 0", MemValid2); end
    vectors++; if (OutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_outvalid: got %b expected 0", OutValid); end
    vectors++; if (OutData !== 16'h0) begin miscompares++; $display("[TB] FAIL mid_outdata: got %h expected 0000", OutData); end
    vectors++; if (InReady !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_inready: got %b expected 1", InReady); end
    CtrlRst = 1'b1; idle(); MemRead2 = 1'b1; MemAddr2 = 16'h001F; tick();
    vectors++; if (MemRData2 !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL mid_ram_kept: got %h expected beef", MemRData2); end
    idle();
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 16'($urandom_range(0, 31)) | (16'($urandom_range(0, 62)) << 10);
    if (r < 9) return IO_BASE + 16'($urandom_range(0, 4));
    return 16'hFFFF - 16'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    for (int i = 0; i < 32; i++) begin
      idle(); MemWrite1 = 1'b1; MemAddr1 = 16'(i); MemWData1 = 16'($urandom); tick();
    end
    for (int n = 0; n < 600; n++) begin
      CtrlRst   = ($urandom_range(0, 49) != 0);
      MemRead1  = ($urandom_range(0, 1) == 1);
      MemWrite1 = ($urandom_range(0, 9) < 3);
      MemAddr1  = rand_addr();
      MemWData1 = 16'($urandom);
      MemRead2  = ($urandom_range(0, 1) == 1);
      MemWrite2 = ($urandom_range(0, 9) < 3);
      MemAddr2  = rand_addr();
      MemWData2 = 16'($urandom);
      OutReady  = ($urandom_range(0, 1) == 1);
      InValid   = ($urandom_range(0, 9) < 3);
      InData    = 16'($urandom);
      tick();
      vectors++; if (MemValid1 !== e_valid1) begin miscompares++; $display("[TB] FAIL rnd_valid1 cyc %0d: got %b expected %b", n, MemValid1, e_valid1); end
      vectors++; if (MemValid2 !== e_valid2) begin miscompares++; $display("[TB] FAIL rnd_valid2 cyc %0d: got %b expected %b", n, MemValid2, e_valid2); end
      vectors++; if (MemRData1 !== e_rdata1) begin miscompares++; $display("[TB] FAIL rnd_rdata1 cyc %0d: got %h expected %h", n, MemRData1, e_rdata1); end
      vectors++; if (MemRData2 !== e_rdata2) begin miscompares++; $display("[TB] FAIL rnd_rdata2 cyc %0d: got %h expected %h", n, MemRData2, e_rdata2); end
      vectors++; if (OutValid !== (m_fifo.size() > 0)) begin miscompares++; $display("[TB] FAIL rnd_outvalid cyc %0d: got %b expected %0d", n, OutValid, m_fifo.size()); end
      vectors++; if (OutData !== ((m_fifo.size() > 0) ? m_fifo[0] : 16'h0)) begin miscompares++; $display("[TB] FAIL rnd_outdata cyc %0d: got %h", n, OutData); end
      vectors++; if (InReady !== !m_in_full) begin miscompares++; $display("[TB] FAIL rnd_inready cyc %0d: got %b expected %b", n, InReady, !m_in_full); end
    end
    CtrlRst = 1'b1; idle();
  endtask

  initial begin
    CtrlRst = 1'b0;
    idle();
    test_reset();
    test_aliasing();
    test_collision();
    test_fifo_overflow();
    test_full_push_pop();
    test_dual_push();
    test_input();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
